// File: rtl/sq_pkg.sv
// Shared widths, FSM encoding and the reference square used by the frame accumulator.
package sq_pkg;
    localparam int A_W    = 8;
    localparam int Y_W    = 16;
    localparam int GPP_W  = 56;
    localparam int GSUM_W = 128;
    localparam int GARB_W = 184;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic logic [Y_W-1:0] square(input logic [A_W-1:0] a);
        return Y_W'(a) * Y_W'(a);
    endfunction
endpackage

// File: rtl/garbage_popcount.sv
// Combinational population count of the 184-bit garbage bus, built as byte chunks then summed.
module garbage_popcount
    import sq_pkg::*;
(
    input  logic [GARB_W-1:0] bits,
    output logic [7:0]        count
);
    localparam int CHUNKS = GARB_W / 8;

    logic [3:0] chunk_cnt [CHUNKS];

    genvar gi;
    generate
        for (gi = 0; gi < CHUNKS; gi++) begin : g_chunk
            assign chunk_cnt[gi] = 4'($countones(bits[gi*8 +: 8]));
        end
    endgenerate

    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            count = count + 8'(chunk_cnt[i]);
        end
    end
endmodule

// File: rtl/squarer_frame_accum.sv
// Frame statistics over squarer results: sum of Y, mismatch count, garbage-ones total and maximum.
module squarer_frame_accum
    import sq_pkg::*;
#(
    parameter int FRAME_LEN = 16,
    parameter int ACC_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [A_W-1:0]    in_a,
    input  logic [Y_W-1:0]    in_y,
    input  logic [GPP_W-1:0]  in_gpp,
    input  logic [GSUM_W-1:0] in_gsum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [15:0]       out_err_cnt,
    output logic [23:0]       out_ones_total,
    output logic [7:0]        out_ones_max
);
    localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

    state_t           state_reg;
    logic [Y_W-1:0]   s1_y_reg;
    logic             s1_err_reg;
    logic [7:0]       s1_ones_reg;
    logic             s1_vld_reg;
    logic [ACC_W-1:0] sum_reg;
    logic [15:0]      err_cnt_reg;
    logic [23:0]      ones_total_reg;
    logic [7:0]       ones_max_reg;
    logic [15:0]      idx_reg;

    logic [7:0]  ones;
    logic        accept;
    logic [15:0] accepted_cnt;

    garbage_popcount u_popcount (
        .bits  ({in_gsum, in_gpp}),
        .count (ones)
    );

    assign in_ready = (state_reg == ACCUM) && !rst;
    assign accept   = in_valid && in_ready;
    // idx lags accepts by one cycle, so include the sample still sitting in S1.
    assign accepted_cnt = idx_reg + 16'(s1_vld_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ACCUM;
            s1_y_reg       <= '0;
            s1_err_reg     <= 1'b0;
            s1_ones_reg    <= '0;
            s1_vld_reg     <= 1'b0;
            sum_reg        <= '0;
            err_cnt_reg    <= '0;
            ones_total_reg <= '0;
            ones_max_reg   <= '0;
            idx_reg        <= '0;
        end else begin
            s1_vld_reg <= accept;
            if (accept) begin
                s1_y_reg    <= in_y;
                s1_err_reg  <= (in_y != square(in_a));
                s1_ones_reg <= ones;
            end

            if (s1_vld_reg) begin
                sum_reg        <= sum_reg + {{(ACC_W-Y_W){1'b0}}, s1_y_reg};
                err_cnt_reg    <= err_cnt_reg + 16'(s1_err_reg);
                ones_total_reg <= ones_total_reg + 24'(s1_ones_reg);
                idx_reg        <= idx_reg + 16'd1;
                if (s1_ones_reg > ones_max_reg) begin
                    ones_max_reg <= s1_ones_reg;
                end
            end

            case (state_reg)
                ACCUM: begin
                    if (accept && accepted_cnt == LAST_IDX) begin
                        state_reg <= FLUSH;
                    end
                end
                FLUSH: state_reg <= HOLD;
                HOLD: begin
                    // S1 is empty in HOLD, so clearing here cannot drop a sample.
                    if (out_ready) begin
                        sum_reg        <= '0;
                        err_cnt_reg    <= '0;
                        ones_total_reg <= '0;
                        ones_max_reg   <= '0;
                        idx_reg        <= '0;
                        state_reg      <= ACCUM;
                    end
                end
                default: state_reg <= ACCUM;
            endcase
        end
    end

    assign out_valid      = (state_reg == HOLD);
    assign out_sum        = sum_reg;
    assign out_err_cnt    = err_cnt_reg;
    assign out_ones_total = ones_total_reg;
    assign out_ones_max   = ones_max_reg;
endmodule
